// File: rtl/min_sched.sv
// min_sched: four requesters share one 2-input unsigned min comparator to compute min(A,B,C).
// Define MIN_SCHED_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module min_sched #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req_valid,
  input  logic [4*DW-1:0] req_a,
  input  logic [4*DW-1:0] req_b,
  input  logic [4*DW-1:0] req_c,
  output logic [3:0]      req_ready,
  output logic            res_valid,
  output logic [DW-1:0]   res_data,
  output logic [1:0]      res_id,
  input  logic            res_ready,
  output logic            busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP1 = 2'd1;
  localparam logic [1:0] S_CMP2 = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;
  logic [1:0]    r_state;
  logic [1:0]    r_cid;
  logic [1:0]    r_id;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_c;
  logic [DW-1:0] r_tmp;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic [1:0]    w_gid;
  logic          w_take;
  logic [DW-1:0] w_x;
  logic [DW-1:0] w_y;
  logic [DW-1:0] w_min;
`ifdef MIN_SCHED_RR_EN
  logic [1:0] r_ptr;
  // Descending scan so the first requester at or after the pointer wins.
  always_comb begin
    w_gid = r_ptr;
    for (int k = 3; k >= 0; k--)
      if (req_valid[r_ptr + 2'(k)]) w_gid = r_ptr + 2'(k);
  end
  always_ff @(posedge clk)
    if (!rst_n) r_ptr <= '0;
    else if (w_take) r_ptr <= w_gid + 2'd1;
`else
  always_comb begin
    w_gid = '0;
    for (int k = 3; k >= 0; k--)
      if (req_valid[k]) w_gid = 2'(k);
  end
`endif
  assign w_take    = rst_n && r_state == S_IDLE && |req_valid;
  assign req_ready = w_take ? 4'b0001 << w_gid : 4'b0000;
  assign busy      = rst_n && r_state != S_IDLE;
  assign res_valid = r_valid;
  assign res_data  = r_data;
  assign res_id    = r_id;
  // CMP1 compares A,B; CMP2 compares the partial result with C.
  assign w_x   = r_state == S_CMP1 ? r_a : r_tmp;
  assign w_y   = r_state == S_CMP1 ? r_b : r_c;
  assign w_min = w_x < w_y ? w_x : w_y;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
      r_tmp   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_take) begin
          r_a     <= req_a[w_gid*DW +: DW];
          r_b     <= req_b[w_gid*DW +: DW];
          r_c     <= req_c[w_gid*DW +: DW];
          r_cid   <= w_gid;
          r_state <= S_CMP1;
        end
        S_CMP1: begin
          r_tmp   <= w_min;
          r_state <= S_CMP2;
        end
        S_CMP2: begin
          r_data  <= w_min;
          r_id    <= r_cid;
          r_valid <= 1'b1;
          r_state <= S_OUT;
        end
        default: if (res_ready) begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
